// File: rtl/pb_pulse_stretch.sv
// Stretches single-cycle strobes into level pulses with a minimum high width and low gap.
// Strobes arriving mid-pulse are queued in a saturating counter and replayed in order.
module pb_pulse_stretch #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_MAX    = 3,
    localparam int unsigned PendW      = $clog2(PEND_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             busy,
    output logic [PendW-1:0] pend_cnt,
    output logic             drop
);

    localparam int unsigned MaxCyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [CntW-1:0]  HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  GapLoad  = CntW'(GAP_CYCLES - 1);
    localparam logic [PendW-1:0] PendFull = PendW'(PEND_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             drop_q, drop_d;
    logic             level_q, level_d;
    logic             pend_nz;
    logic             cnt_zero;

    assign pend_nz  = (pend_q != '0);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pulse_in) begin
                    state_d = StHigh;
                    cnt_d   = HoldLoad;
                end
            end
            StHigh: begin
                if (pulse_in) begin
                    if (pend_q < PendFull) pend_d = pend_q + 1'b1;
                    else                   drop_d = 1'b1;
                end
                if (cnt_zero) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_zero) begin
                    // Final gap cycle: a fresh strobe and a queued one cancel out in the count.
                    if (pend_nz || pulse_in) begin
                        state_d = StHigh;
                        cnt_d   = HoldLoad;
                        if (pend_nz && !pulse_in) pend_d = pend_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (pulse_in) begin
                        if (pend_q < PendFull) pend_d = pend_q + 1'b1;
                        else                   drop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == StHigh);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            level_q <= level_d;
        end
    end

    assign level_out = level_q;
    assign pend_cnt  = pend_q;
    assign drop      = drop_q;
    assign busy      = (state_q != StIdle) || pend_nz;

endmodule

// File: tb/tb_pb_pulse_stretch.sv
// Scoreboard bench: a timeline model predicts every cycle's outputs into a queue and a
// negedge monitor pops and compares them against the DUT.
module tb_pb_pulse_stretch;

    localparam int H = 4;
    localparam int G = 2;
    localparam int P = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_in = 1'b0;
    logic       level_out;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       drop;

    typedef struct packed {
        logic       level;
        logic       busy;
        logic [1:0] pend;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    pb_pulse_stretch #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_MAX   (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = '{level: level_out, busy: busy, pend: pend_cnt, drop: drop};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t: got level=%b busy=%b pend=%0d drop=%b, want level=%b busy=%b pend=%0d drop=%b",
                     name, $time, a.level, a.busy, a.pend, a.drop,
                     e.level, e.busy, e.pend, e.drop);
        end
    endtask

    // Reference model: a pulse is identified by the edge s that started it; its phase is
    // n-s. Level is high for phases 0..H-1 and phase H+G is the final gap edge.
    int edge_n = 0;
    int start_e = 0;
    bit active = 0;
    int pend_m = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                active = 0;
                pend_m = 0;
                edge_n = 0;
                exp_q.delete();
            end else begin
                exp_t e;
                bit   drop_m;
                drop_m = 0;
                if (!active) begin
                    if (pulse_in) begin
                        active  = 1;
                        start_e = edge_n;
                    end
                end else if (edge_n - start_e == H + G) begin
                    if (pend_m > 0 || pulse_in) begin
                        start_e = edge_n;
                        if (pend_m > 0 && !pulse_in) pend_m--;
                    end else begin
                        active = 0;
                    end
                end else if (pulse_in) begin
                    if (pend_m < P) pend_m++;
                    else            drop_m = 1;
                end
                e.level = active && (edge_n - start_e) < H;
                e.busy  = active || pend_m > 0;
                e.pend  = 2'(pend_m);
                e.drop  = drop_m;
                exp_q.push_back(e);
                edge_n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle", exp_q.pop_front());
            else if (!rst) check("in_reset", '0);
        end
    end

    task automatic drive(input logic v);
        @(negedge clk);
        pulse_in = v;
    endtask

    task automatic play(input logic [15:0] pat, input int len);
        for (int i = 0; i < len; i++) drive(pat[i]);
        pulse_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1 check("async_reset", '0);
        @(negedge clk);
        pulse_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] pat;
        int density;
        rst = 1'b0;
        #1 check("reset_state", '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single event, then queued event, then overflow, then final-gap restart.
        pat = 16'h0001; play(pat, 1);  idle(10);
        pat = 16'h0005; play(pat, 3);  idle(16);
        pat = 16'h007f; play(pat, 7);  idle(30);
        pat = 16'h0041; play(pat, 7);  idle(14);

        // Reset while a pulse is high with two events queued.
        pat = 16'h0007; play(pat, 3);
        @(posedge clk);
        async_reset();
        pat = 16'h0001; play(pat, 1);  idle(10);

        for (int blk = 0; blk < 12; blk++) begin
            density = $urandom_range(5, 90);
            for (int i = 0; i < 250; i++) begin
                drive(1'($urandom_range(0, 99) < density));
                if ($urandom_range(0, 399) == 0) async_reset();
            end
        end
        idle(40);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
